signal_generator: RTL and testbench

- Generates a timed output pulse train from the local TC clock time. It is the opposite direction of the signal timestamper: it emits an event at a programmed time instead of capturing the time of an input event.
- The host programs the start time, pulse width, period and repeat count through a valid/ready config interface. The block compares each target against ClockTime and drives the output edges.
- Sits beside the timestamper, fed by the same ClockTime bus; its output goes to an SMA/GPIO pin.

---
 rtl/signal_generator_pkg.sv | 28 ++
 rtl/tc_time_add_ns.sv | 36 +++
 rtl/signal_generator.sv | 154 +++++++++++++++
 tb/tb_signal_generator.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/signal_generator_pkg.sv
// rtl/signal_generator_pkg.sv - shared types and constants for the timed pulse generator
package signal_generator_pkg;

    typedef struct packed {
        logic [31:0] second;
        logic [31:0] nanosecond;
    } ClockTime_Type;

    localparam logic [31:0] SecondNanoseconds_Con = 32'd1_000_000_000;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ARMED,
        HIGH,
        LOW
    } state_t;

    localparam int ERR_BAD_CONFIG    = 0;
    localparam int ERR_START_IN_PAST = 1;
    localparam int ERR_TIME          = 2;

    function automatic logic time_reached(input ClockTime_Type now_t, input ClockTime_Type target_t);
        return (now_t.second > target_t.second) ||
               ((now_t.second == target_t.second) && (now_t.nanosecond >= target_t.nanosecond));
    endfunction

endpackage

// File: rtl/tc_time_add_ns.sv
// rtl/tc_time_add_ns.sv - combinational time +/- nanoseconds with second carry/borrow
module tc_time_add_ns
    import signal_generator_pkg::*;
#(
    parameter bit Subtract = 1'b0
) (
    input  ClockTime_Type i_time,
    input  logic [31:0]   i_ns,
    output ClockTime_Type o_time
);

    logic [31:0] w_sum;

    // Operands stay below 1e9, so the sum fits in 32 bits before the wrap.
    assign w_sum = i_time.nanosecond + i_ns;

    always_comb begin
        o_time = i_time;
        if (Subtract) begin
            if (i_time.nanosecond < i_ns) begin
                o_time.nanosecond = i_time.nanosecond + SecondNanoseconds_Con - i_ns;
                o_time.second     = i_time.second - 32'd1;
            end else begin
                o_time.nanosecond = i_time.nanosecond - i_ns;
            end
        end else begin
            if (w_sum >= SecondNanoseconds_Con) begin
                o_time.nanosecond = w_sum - SecondNanoseconds_Con;
                o_time.second     = i_time.second + 32'd1;
            end else begin
                o_time.nanosecond = w_sum;
            end
        end
    end

endmodule

// File: rtl/signal_generator.sv
// rtl/signal_generator.sv - programmable pulse train generator timed from ClockTime
module signal_generator
    import signal_generator_pkg::*;
#(
    parameter int unsigned ClockPeriod_Gen    = 20,
    parameter int unsigned OutputDelay_Gen    = 0,
    parameter string       OutputPolarity_Gen = "true"
) (
    input  logic        SysClk_ClkIn,
    input  logic        SysRst_RstIn,
    input  logic [31:0] ClockTime_Second_DatIn,
    input  logic [31:0] ClockTime_Nanosecond_DatIn,
    input  logic        ClockTime_TimeJump_DatIn,
    input  logic        ClockTime_ValIn,
    input  logic        Cfg_ValIn,
    output logic        Cfg_RdyOut,
    input  logic [31:0] CfgStartSecond_DatIn,
    input  logic [31:0] CfgStartNanosecond_DatIn,
    input  logic [31:0] CfgPulseHigh_DatIn,
    input  logic [31:0] CfgPeriod_DatIn,
    input  logic [31:0] CfgRepeat_DatIn,
    input  logic        Abort_EvtIn,
    output logic        SignalGenerator_EvtOut,
    output logic        Busy_StaOut,
    output logic        Done_EvtOut,
    output logic [2:0]  Error_DatOut
);

    // Targets fire one cycle early so the output register lands on the nominal edge.
    localparam logic [31:0] COMP_NS     = 32'(OutputDelay_Gen + ClockPeriod_Gen);
    localparam bit          ACTIVE_HIGH = (OutputPolarity_Gen == "true");

    state_t        r_state;
    ClockTime_Type r_rise;
    logic [31:0]   r_high;
    logic [31:0]   r_period;
    logic [31:0]   r_repeat;
    logic [31:0]   r_count;
    logic          r_active;
    logic          r_done;
    logic [2:0]    r_err;

    ClockTime_Type w_now;
    ClockTime_Type w_rise_cmp;
    ClockTime_Type w_fall_nom;
    ClockTime_Type w_fall_cmp;
    ClockTime_Type w_next_rise;
    logic          w_rise_hit;
    logic          w_fall_hit;
    logic          w_bad_cfg;
    logic          w_past;
    logic          w_time_err;
    logic          w_stop;
    logic          w_running;
    logic          w_accept;
    logic          w_last;

    assign w_now = '{second: ClockTime_Second_DatIn, nanosecond: ClockTime_Nanosecond_DatIn};

    // r_rise always holds the nominal rise so repeated additions never accumulate error.
    tc_time_add_ns #(.Subtract(1'b1)) u_rise_cmp (.i_time(r_rise),     .i_ns(COMP_NS),  .o_time(w_rise_cmp));
    tc_time_add_ns #(.Subtract(1'b0)) u_fall_nom (.i_time(r_rise),     .i_ns(r_high),   .o_time(w_fall_nom));
    tc_time_add_ns #(.Subtract(1'b1)) u_fall_cmp (.i_time(w_fall_nom), .i_ns(COMP_NS),  .o_time(w_fall_cmp));
    tc_time_add_ns #(.Subtract(1'b0)) u_next     (.i_time(r_rise),     .i_ns(r_period), .o_time(w_next_rise));

    assign w_rise_hit = time_reached(w_now, w_rise_cmp);
    assign w_fall_hit = time_reached(w_now, w_fall_cmp);
    assign w_bad_cfg  = (r_high == 32'd0) || (r_high >= r_period) ||
                        (r_period >= SecondNanoseconds_Con) ||
                        (r_rise.nanosecond >= SecondNanoseconds_Con);
    assign w_past     = !ClockTime_ValIn || w_rise_hit;
    assign w_time_err = ClockTime_TimeJump_DatIn || !ClockTime_ValIn;
    assign w_stop     = Abort_EvtIn || w_time_err;
    assign w_running  = (r_state == ARMED) || (r_state == HIGH) || (r_state == LOW);
    assign w_accept   = Cfg_ValIn && Cfg_RdyOut;
    assign w_last     = (r_repeat != 32'd0) && (r_count == r_repeat);

    always_ff @(posedge SysClk_ClkIn) begin
        if (SysRst_RstIn) begin
            r_state  <= IDLE;
            r_rise   <= '0;
            r_high   <= '0;
            r_period <= '0;
            r_repeat <= '0;
            r_count  <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_running && w_stop) begin
                r_active <= 1'b0;
                r_state  <= IDLE;
                if (w_time_err) begin
                    r_err[ERR_TIME] <= 1'b1;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_rise   <= '{second: CfgStartSecond_DatIn, nanosecond: CfgStartNanosecond_DatIn};
                            r_high   <= CfgPulseHigh_DatIn;
                            r_period <= CfgPeriod_DatIn;
                            r_repeat <= CfgRepeat_DatIn;
                            r_count  <= '0;
                            r_err    <= '0;
                            r_state  <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (Abort_EvtIn) begin
                            r_state <= IDLE;
                        end else if (w_bad_cfg || w_past) begin
                            r_err[ERR_BAD_CONFIG]    <= r_err[ERR_BAD_CONFIG] | w_bad_cfg;
                            r_err[ERR_START_IN_PAST] <= r_err[ERR_START_IN_PAST] | w_past;
                            r_state                  <= IDLE;
                        end else begin
                            r_state <= ARMED;
                        end
                    end
                    ARMED, LOW: begin
                        if (w_rise_hit) begin
                            r_active <= 1'b1;
                            r_state  <= HIGH;
                            if ((r_repeat != 32'd0) && (r_count != r_repeat)) begin
                                r_count <= r_count + 32'd1;
                            end
                        end
                    end
                    HIGH: begin
                        if (w_fall_hit) begin
                            r_active <= 1'b0;
                            r_rise   <= w_next_rise;
                            if (w_last) begin
                                r_done  <= 1'b1;
                                r_state <= IDLE;
                            end else begin
                                r_state <= LOW;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign Cfg_RdyOut             = (r_state == IDLE) && !Abort_EvtIn;
    assign Busy_StaOut            = (r_state != IDLE);
    assign Done_EvtOut            = r_done;
    assign Error_DatOut           = r_err;
    assign SignalGenerator_EvtOut = ACTIVE_HIGH ? r_active : ~r_active;

endmodule

// File: tb/tb_signal_generator.sv
// tb/tb_signal_generator.sv - self-checking bench for signal_generator against an absolute-time pulse model
module tb_signal_generator;

    localparam longint NS = 64'd1_000_000_000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ct_sec;
    logic [31:0] ct_ns;
    logic        tjump;
    logic        tval;
    logic        cfg_val;
    logic [31:0] cfg_start_sec;
    logic [31:0] cfg_start_ns;
    logic [31:0] cfg_high;
    logic [31:0] cfg_period;
    logic [31:0] cfg_repeat;
    logic        abort_evt;

    logic        rdy_h, sig_h, busy_h, done_h;
    logic [2:0]  err_h;
    logic        rdy_l, sig_l, busy_l, done_l;
    logic [2:0]  err_l;

    int          n_checks = 0;
    int          n_pass   = 0;

    int          obs_bad;
    int          obs_dones;
    longint      obs_bad_t;
    longint      obs_rise[$];
    longint      obs_fall[$];

    always #5 clk = ~clk;

    signal_generator dut_h (
        .SysClk_ClkIn(clk), .SysRst_RstIn(rst),
        .ClockTime_Second_DatIn(ct_sec), .ClockTime_Nanosecond_DatIn(ct_ns),
        .ClockTime_TimeJump_DatIn(tjump), .ClockTime_ValIn(tval),
        .Cfg_ValIn(cfg_val), .Cfg_RdyOut(rdy_h),
        .CfgStartSecond_DatIn(cfg_start_sec), .CfgStartNanosecond_DatIn(cfg_start_ns),
        .CfgPulseHigh_DatIn(cfg_high), .CfgPeriod_DatIn(cfg_period), .CfgRepeat_DatIn(cfg_repeat),
        .Abort_EvtIn(abort_evt), .SignalGenerator_EvtOut(sig_h),
        .Busy_StaOut(busy_h), .Done_EvtOut(done_h), .Error_DatOut(err_h)
    );

    signal_generator #(.OutputPolarity_Gen("false")) dut_l (
        .SysClk_ClkIn(clk), .SysRst_RstIn(rst),
        .ClockTime_Second_DatIn(ct_sec), .ClockTime_Nanosecond_DatIn(ct_ns),
        .ClockTime_TimeJump_DatIn(tjump), .ClockTime_ValIn(tval),
        .Cfg_ValIn(cfg_val), .Cfg_RdyOut(rdy_l),
        .CfgStartSecond_DatIn(cfg_start_sec), .CfgStartNanosecond_DatIn(cfg_start_ns),
        .CfgPulseHigh_DatIn(cfg_high), .CfgPeriod_DatIn(cfg_period), .CfgRepeat_DatIn(cfg_repeat),
        .Abort_EvtIn(abort_evt), .SignalGenerator_EvtOut(sig_l),
        .Busy_StaOut(busy_l), .Done_EvtOut(done_l), .Error_DatOut(err_l)
    );

    function automatic longint now_ns();
        return longint'({32'd0, ct_sec}) * NS + longint'({32'd0, ct_ns});
    endfunction

    // Pulse k is active over [start + k*period, start + k*period + high).
    function automatic bit model_active(longint t, longint st, longint hi, longint pe, int rep);
        longint k;
        if (t < st) return 1'b0;
        k = (t - st) / pe;
        if (rep != 0 && k >= longint'(rep)) return 1'b0;
        return ((t - st) % pe) < hi;
    endfunction

    task automatic set_time(input longint t);
        ct_sec = 32'(t / NS);
        ct_ns  = 32'(t % NS);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ct_ns = ct_ns + 32'd20;
        if (ct_ns >= 32'd1_000_000_000) begin
            ct_ns  = ct_ns - 32'd1_000_000_000;
            ct_sec = ct_sec + 32'd1;
        end
    endtask

    task automatic accept(input logic [31:0] s, input logic [31:0] ns, input logic [31:0] hi,
                          input logic [31:0] pe, input logic [31:0] rep);
        cfg_start_sec = s;
        cfg_start_ns  = ns;
        cfg_high      = hi;
        cfg_period    = pe;
        cfg_repeat    = rep;
        cfg_val       = 1'b1;
        step();
        cfg_val       = 1'b0;
    endtask

    task automatic observe(input longint st, input longint hi, input longint pe, input int rep, input int ncyc);
        longint t;
        longint lf;
        bit     ea, ed, eb, prev;
        lf        = st + longint'(rep - 1) * pe + hi;
        obs_bad   = 0;
        obs_dones = 0;
        obs_bad_t = -1;
        obs_rise.delete();
        obs_fall.delete();
        prev = sig_h;
        for (int i = 0; i < ncyc; i++) begin
            step();
            t  = now_ns();
            ea = model_active(t, st, hi, pe, rep);
            ed = (rep != 0) && (t >= lf) && (t < lf + 20);
            eb = (rep == 0) || (t < lf);
            if (sig_h !== ea || sig_l !== !ea || done_h !== ed || done_l !== ed ||
                busy_h !== eb || rdy_h !== !eb || err_h !== 3'b000) begin
                obs_bad++;
                if (obs_bad_t < 0) obs_bad_t = t;
            end
            if (sig_h === 1'b1 && !prev) obs_rise.push_back(t);
            if (sig_h === 1'b0 && prev) obs_fall.push_back(t);
            prev = sig_h;
            if (done_h === 1'b1) obs_dones++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_checks++; if (sig_h !== 1'b0) $display("FAIL reset_sig_h: got %b expected 0", sig_h); else n_pass++;
        n_checks++; if (sig_l !== 1'b1) $display("FAIL reset_sig_l: got %b expected 1", sig_l); else n_pass++;
        n_checks++; if (busy_h !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_h); else n_pass++;
        n_checks++; if (done_h !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_h); else n_pass++;
        n_checks++; if (err_h !== 3'b000) $display("FAIL reset_err: got %b expected 000", err_h); else n_pass++;
        n_checks++; if (rdy_h !== 1'b1) $display("FAIL reset_rdy: got %b expected 1", rdy_h); else n_pass++;
    endtask

    task automatic test_basic_train();
        longint st;
        set_time(10 * NS);
        st = 10 * NS + 1000;
        accept(32'd10, 32'd1000, 32'd100, 32'd200, 32'd3);
        n_checks++; if (busy_h !== 1'b1 || err_h !== 3'b000) $display("FAIL basic_check_state: busy %b err %b expected busy 1 err 000", busy_h, err_h); else n_pass++;
        observe(st, 100, 200, 3, 90);
        n_checks++; if (obs_bad !== 0) $display("FAIL basic_wave: %0d bad cycles, first at %0d ns, expected 0", obs_bad, obs_bad_t); else n_pass++;
        n_checks++; if (obs_rise.size() !== 3) $display("FAIL basic_pulses: got %0d expected 3", obs_rise.size()); else n_pass++;
        n_checks++; if ((obs_rise.size() > 0 ? obs_rise[0] : -1) !== st) $display("FAIL basic_first_rise: got %0d expected %0d", (obs_rise.size() > 0 ? obs_rise[0] : -1), st); else n_pass++;
        n_checks++; if (obs_dones !== 1) $display("FAIL basic_done: got %0d pulses expected 1", obs_dones); else n_pass++;
        n_checks++; if (rdy_h !== 1'b1) $display("FAIL basic_rdy_after: got %b expected 1", rdy_h); else n_pass++;
    endtask

    task automatic test_ns_wrap();
        set_time(5 * NS + 999_999_000);
        accept(32'd5, 32'd999_999_900, 32'd200, 32'd400, 32'd2);
        observe(5 * NS + 999_999_900, 200, 400, 2, 100);
        n_checks++; if (obs_bad !== 0) $display("FAIL wrap_wave: %0d bad cycles, first at %0d ns, expected 0", obs_bad, obs_bad_t); else n_pass++;
        n_checks++; if ((obs_fall.size() > 0 ? obs_fall[0] : -1) !== 6 * NS + 100) $display("FAIL wrap_first_fall: got %0d expected %0d", (obs_fall.size() > 0 ? obs_fall[0] : -1), 6 * NS + 100); else n_pass++;
        n_checks++; if ((obs_rise.size() > 1 ? obs_rise[1] : -1) !== 6 * NS + 300) $display("FAIL wrap_second_rise: got %0d expected %0d", (obs_rise.size() > 1 ? obs_rise[1] : -1), 6 * NS + 300); else n_pass++;
        n_checks++; if (obs_dones !== 1) $display("FAIL wrap_done: got %0d pulses expected 1", obs_dones); else n_pass++;
    endtask

    task automatic test_random_trains();
        longint base, st, hi, pe, off;
        int     rep;
        for (int i = 0; i < 5; i++) begin
            base = longint'($urandom_range(1, 1000)) * NS;
            if (i % 2 == 1) base = base + NS - 20 * longint'($urandom_range(1, 60));
            else            base = base + 20 * longint'($urandom_range(0, 49_999_999));
            set_time(base);
            off = longint'($urandom_range(200, 3000));
            hi  = longint'($urandom_range(40, 400));
            pe  = hi + longint'($urandom_range(40, 400));
            rep = int'($urandom_range(1, 4));
            st  = base + off;
            accept(32'(st / NS), 32'(st % NS), 32'(hi), 32'(pe), 32'(rep));
            observe(st, hi, pe, rep, int'((off + longint'(rep) * pe) / 20) + 10);
            n_checks++; if (obs_bad !== 0) $display("FAIL rand%0d_wave: %0d bad cycles, first at %0d ns, expected 0", i, obs_bad, obs_bad_t); else n_pass++;
            n_checks++; if (obs_rise.size() !== rep) $display("FAIL rand%0d_pulses: got %0d expected %0d", i, obs_rise.size(), rep); else n_pass++;
            n_checks++; if (obs_dones !== 1) $display("FAIL rand%0d_done: got %0d pulses expected 1", i, obs_dones); else n_pass++;
        end
    endtask

    task automatic test_start_in_past();
        int act;
        set_time(20 * NS);
        accept(32'd19, 32'd999_999_980, 32'd100, 32'd200, 32'd1);
        step();
        n_checks++; if (err_h !== 3'b010) $display("FAIL past_err: got %b expected 010", err_h); else n_pass++;
        n_checks++; if (busy_h !== 1'b0) $display("FAIL past_busy: got %b expected 0", busy_h); else n_pass++;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (sig_h !== 1'b0 || busy_h !== 1'b0) act++;
        end
        n_checks++; if (act !== 0) $display("FAIL past_idle: got %0d active cycles expected 0", act); else n_pass++;
        accept(32'd21, 32'd0, 32'd100, 32'd200, 32'd1);
        tval = 1'b0;
        step();
        tval = 1'b1;
        n_checks++; if (err_h !== 3'b010) $display("FAIL invalid_clock_err: got %b expected 010", err_h); else n_pass++;
    endtask

    task automatic test_bad_config();
        logic [31:0] hi_t[5] = '{32'd300, 32'd200, 32'd0, 32'd100, 32'd100};
        logic [31:0] pe_t[5] = '{32'd200, 32'd200, 32'd200, 32'd1_000_000_000, 32'd200};
        logic [31:0] ns_t[5] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1_000_000_000};
        for (int i = 0; i < 5; i++) begin
            set_time(30 * NS);
            accept(32'd31, ns_t[i], hi_t[i], pe_t[i], 32'd1);
            step();
            n_checks++; if (err_h !== 3'b001 || busy_h !== 1'b0 || rdy_h !== 1'b1)
                $display("FAIL bad_cfg%0d: err %b busy %b rdy %b expected err 001 busy 0 rdy 1", i, err_h, busy_h, rdy_h); else n_pass++;
        end
    endtask

    task automatic test_time_jump();
        int pre[3] = '{52, 62, 2};
        int dn;
        for (int v = 0; v < 3; v++) begin
            set_time(40 * NS);
            accept(32'd40, 32'd1000, 32'd200, 32'd400, 32'd3);
            for (int i = 0; i < pre[v]; i++) step();
            if (v == 0) begin
                n_checks++; if (sig_h !== 1'b1) $display("FAIL jump_pre_high: got %b expected 1", sig_h); else n_pass++;
            end
            tjump     = (v != 1);
            tval      = (v != 1);
            abort_evt = (v == 2);
            step();
            tjump     = 1'b0;
            tval      = 1'b1;
            abort_evt = 1'b0;
            n_checks++; if (err_h !== 3'b100) $display("FAIL jump%0d_err: got %b expected 100", v, err_h); else n_pass++;
            n_checks++; if (sig_h !== 1'b0 || sig_l !== 1'b1 || busy_h !== 1'b0)
                $display("FAIL jump%0d_stop: sig_h %b sig_l %b busy %b expected 0 1 0", v, sig_h, sig_l, busy_h); else n_pass++;
            dn = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (done_h !== 1'b0 || sig_h !== 1'b0) dn++;
            end
            n_checks++; if (dn !== 0) $display("FAIL jump%0d_quiet: got %0d active cycles expected 0", v, dn); else n_pass++;
        end
    endtask

    task automatic test_infinite_abort();
        int dn;
        set_time(50 * NS);
        accept(32'd50, 32'd1000, 32'd100, 32'd200, 32'd0);
        observe(50 * NS + 1000, 100, 200, 0, 147);
        n_checks++; if (obs_bad !== 0) $display("FAIL inf_wave: %0d bad cycles, first at %0d ns, expected 0", obs_bad, obs_bad_t); else n_pass++;
        n_checks++; if (obs_rise.size() !== 10) $display("FAIL inf_pulses: got %0d expected 10", obs_rise.size()); else n_pass++;
        abort_evt = 1'b1;
        step();
        n_checks++; if (sig_l !== 1'b1 || sig_h !== 1'b0) $display("FAIL inf_abort_out: sig_l %b sig_h %b expected 1 0", sig_l, sig_h); else n_pass++;
        n_checks++; if (busy_l !== 1'b0 || rdy_l !== 1'b0 || err_l !== 3'b000)
            $display("FAIL inf_abort_state: busy %b rdy %b err %b expected 0 0 000", busy_l, rdy_l, err_l); else n_pass++;
        abort_evt = 1'b0;
        #1;
        n_checks++; if (rdy_l !== 1'b1) $display("FAIL inf_rdy_release: got %b expected 1", rdy_l); else n_pass++;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done_l !== 1'b0 || sig_l !== 1'b1 || err_l !== 3'b000) dn++;
        end
        n_checks++; if (dn !== 0) $display("FAIL inf_quiet: got %0d bad cycles expected 0", dn); else n_pass++;
    endtask

    task automatic test_abort_in_check();
        int act;
        set_time(60 * NS);
        accept(32'd60, 32'd1000, 32'd100, 32'd200, 32'd1);
        abort_evt = 1'b1;
        step();
        abort_evt = 1'b0;
        n_checks++; if (busy_h !== 1'b0 || err_h !== 3'b000) $display("FAIL check_abort: busy %b err %b expected 0 000", busy_h, err_h); else n_pass++;
        act = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (sig_h !== 1'b0 || busy_h !== 1'b0) act++;
        end
        n_checks++; if (act !== 0) $display("FAIL check_abort_quiet: got %0d active cycles expected 0", act); else n_pass++;
    endtask

    task automatic test_reset_mid();
        set_time(70 * NS);
        accept(32'd70, 32'd500, 32'd200, 32'd400, 32'd2);
        for (int i = 0; i < 26; i++) step();
        n_checks++; if (sig_h !== 1'b1) $display("FAIL rstmid_pre_high: got %b expected 1", sig_h); else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (sig_h !== 1'b0 || sig_l !== 1'b1 || busy_h !== 1'b0)
            $display("FAIL rstmid_out: sig_h %b sig_l %b busy %b expected 0 1 0", sig_h, sig_l, busy_h); else n_pass++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        ct_sec        = '0;
        ct_ns         = '0;
        tjump         = 1'b0;
        tval          = 1'b1;
        cfg_val       = 1'b0;
        cfg_start_sec = '0;
        cfg_start_ns  = '0;
        cfg_high      = '0;
        cfg_period    = '0;
        cfg_repeat    = '0;
        abort_evt     = 1'b0;
        test_reset();
        test_basic_train();
        test_ns_wrap();
        test_random_trains();
        test_start_in_past();
        test_bad_config();
        test_time_jump();
        test_infinite_abort();
        test_abort_in_check();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
